// File: rtl/simd_pkg.sv
// Shared definitions for the lane-wise SIMD arithmetic units.
package simd_pkg;

    // Lane width is fixed at 8 bits for this release.
    localparam int LANE_BITS  = 8;

    // Number of operand bits handled per clock by the chunked engines.
    localparam int CHUNK_BITS = 64;

    // Operation sequencing shared by the chunked lane-wise units.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of independent lanes in a bus of the given width.
    function automatic int num_lanes(input int width);
        return width / LANE_BITS;
    endfunction

endpackage

// File: rtl/chunk_sub.sv
// Combinational lane-wise subtractor for one chunk: each lane computes
// (dd - aa) mod 2^lane_bits independently and flags an unsigned borrow.
module chunk_sub
    import simd_pkg::*;
#(
    parameter int chunk_bits = CHUNK_BITS,
    parameter int lane_bits  = LANE_BITS
) (
    input  logic [chunk_bits-1:0]           dd_i,
    input  logic [chunk_bits-1:0]           aa_i,
    output logic [chunk_bits-1:0]           diff_o,
    output logic [chunk_bits/lane_bits-1:0] borrow_o
);

    localparam int LANES = chunk_bits / lane_bits;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // One extra bit captures the borrow; lanes never see each other.
            logic [lane_bits:0] wide;

            assign wide = {1'b0, dd_i[gi*lane_bits +: lane_bits]}
                        - {1'b0, aa_i[gi*lane_bits +: lane_bits]};
            assign diff_o[gi*lane_bits +: lane_bits] = wide[lane_bits-1:0];
            assign borrow_o[gi]                      = wide[lane_bits];
        end
    endgenerate

endmodule

// File: rtl/simd_subtractor.sv
// Multi-cycle lane-wise subtractor. Operands are captured on accept, then one
// chunk is processed per cycle from the low chunk upward; the full result is
// held with out_valid until the consumer takes it.
module simd_subtractor
    import simd_pkg::*;
#(
    parameter int num_bits   = 512,
    parameter int lane_bits  = LANE_BITS,
    parameter int chunk_bits = CHUNK_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [num_bits-1:0]           dd,
    input  logic [num_bits-1:0]           aa,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [num_bits-1:0]           diff,
    output logic [num_bits/lane_bits-1:0] borrow,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int NUM_CHUNKS  = num_bits / chunk_bits;
    localparam int CHUNK_LANES = chunk_bits / lane_bits;
    localparam int CNT_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [num_bits-1:0]           dd_q, dd_d;
    logic [num_bits-1:0]           aa_q, aa_d;
    logic [num_bits-1:0]           diff_q, diff_d;
    logic [num_bits/lane_bits-1:0] borrow_q, borrow_d;
    logic                          out_valid_q, out_valid_d;

    logic [chunk_bits-1:0]         dd_chunk;
    logic [chunk_bits-1:0]         aa_chunk;
    logic [chunk_bits-1:0]         chunk_diff;
    logic [CHUNK_LANES-1:0]        chunk_borrow;

    // Select the chunk addressed by the counter from the captured operands.
    assign dd_chunk = dd_q[int'(cnt_q)*chunk_bits +: chunk_bits];
    assign aa_chunk = aa_q[int'(cnt_q)*chunk_bits +: chunk_bits];

    chunk_sub #(
        .chunk_bits (chunk_bits),
        .lane_bits  (lane_bits)
    ) u_chunk_sub (
        .dd_i     (dd_chunk),
        .aa_i     (aa_chunk),
        .diff_o   (chunk_diff),
        .borrow_o (chunk_borrow)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign out_valid = out_valid_q;

    // Next-state logic: accept in IDLE, one chunk per BUSY cycle, hold in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dd_d        = dd_q;
        aa_d        = aa_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dd_d    = dd;
                    aa_d    = aa;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Only the current chunk's slices are written this cycle.
                diff_d[int'(cnt_q)*chunk_bits +: chunk_bits]      = chunk_diff;
                borrow_d[int'(cnt_q)*CHUNK_LANES +: CHUNK_LANES]  = chunk_borrow;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dd_q        <= '0;
            aa_q        <= '0;
            diff_q      <= '0;
            borrow_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dd_q        <= dd_d;
            aa_q        <= aa_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_simd_subtractor.sv
// Directed testbench for simd_subtractor with hand-computed expectations.
module tb_simd_subtractor;

    localparam int NB = 512;
    localparam int NL = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] dd = '0;
    logic [NB-1:0] aa = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] diff;
    logic [NL-1:0] borrow;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    simd_subtractor #(
        .num_bits   (NB),
        .lane_bits  (8),
        .chunk_bits (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dd        (dd),
        .aa        (aa),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .borrow    (borrow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] rep(input logic [7:0] b);
        logic [NB-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid and check the edge count since the accept.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, NB'(lat), NB'(8));
    endtask

    // Present operands, accept, then scramble the inputs to show they are captured.
    task automatic start_op(input string tag, input logic [NB-1:0] d, input logic [NB-1:0] a);
        check({tag, "_in_ready"}, NB'(in_ready), NB'(1));
        dd       = d;
        aa       = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dd       = ~d;
        aa       = ~a;
        wait_result(tag);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, NB'(out_valid), NB'(0));
        check({tag, "_ready_back"}, NB'(in_ready), NB'(1));
    endtask

    task automatic run_op(input string tag, input logic [NB-1:0] d, input logic [NB-1:0] a,
                          input logic [NB-1:0] exp_diff, input logic [NL-1:0] exp_borrow);
        start_op(tag, d, a);
        check({tag, "_diff"}, diff, exp_diff);
        check({tag, "_borrow"}, NB'(borrow), NB'(exp_borrow));
        finish_op(tag);
        $display("txn %s done checks=%0d errors=%0d", tag, checks, errors);
    endtask

    initial begin
        logic [NB-1:0] a_v;
        logic [NB-1:0] e_v;
        logic [NL-1:0] b_v;
        bit            seen;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_in_ready", NB'(in_ready), NB'(1));
        check("rst_out_valid", NB'(out_valid), NB'(0));
        check("rst_diff", diff, '0);
        check("rst_borrow", NB'(borrow), '0);

        // Basic lane-wise subtraction.
        run_op("sub05_01", rep(8'h05), rep(8'h01), rep(8'h04), '0);

        // Single lane wraps without disturbing neighbours.
        a_v = '0;
        a_v[7:0] = 8'h01;
        e_v = '0;
        e_v[7:0] = 8'hFF;
        run_op("lane0", '0, a_v, e_v, 64'h1);

        // Walk the wrapping lane across all positions.
        for (int k = 0; k < NL; k++) begin
            a_v = '0;
            a_v[k*8 +: 8] = 8'h01;
            e_v = '0;
            e_v[k*8 +: 8] = 8'hFF;
            b_v = '0;
            b_v[k] = 1'b1;
            run_op($sformatf("walk%0d", k), '0, a_v, e_v, b_v);
        end

        // Extremes.
        run_op("ff_ff", rep(8'hFF), rep(8'hFF), '0, '0);
        run_op("00_ff", rep(8'h00), rep(8'hFF), rep(8'h01), '1);

        // Back-pressure in DONE with new operands waiting.
        start_op("hold", rep(8'h05), rep(8'h01));
        dd        = rep(8'h10);
        aa        = rep(8'h03);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_diff", c), diff, rep(8'h04));
            check($sformatf("hold%0d_valid", c), NB'(out_valid), NB'(1));
            check($sformatf("hold%0d_in_ready", c), NB'(in_ready), NB'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_valid_clr", NB'(out_valid), NB'(0));
        check("hold_ready_back", NB'(in_ready), NB'(1));
        tick();
        in_valid = 1'b0;
        check("hold_second_accept", NB'(in_ready), NB'(0));
        wait_result("hold2");
        check("hold2_diff", diff, rep(8'h0D));
        check("hold2_borrow", NB'(borrow), '0);
        finish_op("hold2");
        $display("txn hold done checks=%0d errors=%0d", checks, errors);

        // Reset in the middle of BUSY aborts the operation.
        dd       = rep(8'h05);
        aa       = rep(8'h01);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", NB'(out_valid), NB'(0));
        check("abort_diff", diff, '0);
        check("abort_borrow", NB'(borrow), '0);
        check("abort_in_ready", NB'(in_ready), NB'(1));
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", NB'(seen), NB'(0));
        $display("txn abort done checks=%0d errors=%0d", checks, errors);

        // Recovery after abort.
        run_op("recover", rep(8'h80), rep(8'h7F), rep(8'h01), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
